// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the command sequencer: frame command bytes, ALU operand
// register addresses and the sequencer state encoding.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_WR_ADDR  = 4'd1;
  localparam state_t ST_WR_DATA  = 4'd2;
  localparam state_t ST_RD_ADDR  = 4'd3;
  localparam state_t ST_RD_WAIT  = 4'd4;
  localparam state_t ST_ALU_A    = 4'd5;
  localparam state_t ST_ALU_B    = 4'd6;
  localparam state_t ST_ALU_FN   = 4'd7;
  localparam state_t ST_ALU_WAIT = 4'd8;
  localparam state_t ST_TX_LSB   = 4'd9;
  localparam state_t ST_TX_MSB   = 4'd10;

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// Response serializer: holds the captured result and presents it to the TX FIFO
// LSB first, writing only while the FIFO has room.
module sys_ctrl_tx_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [RES_WIDTH-1:0]  load_data,
  input  logic                  load_two,
  input  logic                  send_lsb,
  input  logic                  send_msb,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_wr,
  output logic                  two_byte
);

  logic [RES_WIDTH-1:0] result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      two_byte <= 1'b0;
    end else if (load) begin
      result   <= load_data;
      two_byte <= load_two;
    end
  end

  // A stalled byte simply stays presented until the FIFO frees up.
  assign fifo_wr   = (send_lsb | send_msb) & ~fifo_full;
  assign fifo_data = send_msb ? result[DATA_WIDTH +: DATA_WIDTH] : result[DATA_WIDTH-1:0];

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes UART frames into register-file writes/reads and ALU
// operations, gates the ALU clock, and queues response bytes for transmit.
//
// state     | meaning
// IDLE      | waiting for a command byte
// WR_ADDR   | reg write, expecting address byte
// WR_DATA   | reg write, expecting data byte
// RD_ADDR   | reg read, expecting address byte
// RD_WAIT   | reg read issued, waiting for read data
// ALU_A     | expecting operand A (stored at reg 0)
// ALU_B     | expecting operand B (stored at reg 1)
// ALU_FN    | expecting function byte, then launching the ALU
// ALU_WAIT  | ALU running, waiting for result
// TX_LSB    | pushing result low byte
// TX_MSB    | pushing result high byte
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]    RF_ADDR,
  output logic                     RF_WR_EN,
  output logic                     RF_RD_EN,
  output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
  input  logic                     RF_RD_VLD,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                     ALU_EN,
  output logic                     ALU_CLK_EN,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]    TX_FIFO_DATA,
  output logic                     TX_FIFO_WR,
  input  logic                     TX_FIFO_FULL,
  output logic                     BUSY
);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    fn_got;
  logic                    res_load;
  logic                    res_two;
  logic [ALU_OUT_WIDTH-1:0] res_data;
  logic                    two_byte;

  assign BUSY = (state != ST_IDLE);

  always_comb begin
    res_load = 1'b0;
    res_two  = 1'b0;
    res_data = ALU_OUT;
    if (state == ST_RD_WAIT && RF_RD_VLD) begin
      res_load = 1'b1;
      res_data = ALU_OUT_WIDTH'(RF_RD_DATA);
    end else if (state == ST_ALU_WAIT && ALU_OUT_VLD) begin
      res_load = 1'b1;
      res_two  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      fn_got     <= 1'b0;
      RF_ADDR    <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      RF_WR_DATA <= '0;
      ALU_FUN    <= '0;
      ALU_EN     <= 1'b0;
      ALU_CLK_EN <= 1'b0;
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      ALU_EN   <= 1'b0;
      case (state)
        ST_IDLE: if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_RF_WR:   state <= ST_WR_ADDR;
            CMD_RF_RD:   state <= ST_RD_ADDR;
            CMD_ALU_OP:  state <= ST_ALU_A;
            CMD_ALU_NOP: state <= ST_ALU_FN;
            default:     state <= ST_IDLE;
          endcase
        end
        ST_WR_ADDR: if (RX_D_VLD) begin
          addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
          state  <= ST_WR_DATA;
        end
        ST_WR_DATA: if (RX_D_VLD) begin
          RF_ADDR    <= addr_q;
          RF_WR_DATA <= RX_P_DATA;
          RF_WR_EN   <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_RD_ADDR: if (RX_D_VLD) begin
          RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
          RF_RD_EN <= 1'b1;
          state    <= ST_RD_WAIT;
        end
        ST_RD_WAIT: if (RF_RD_VLD) state <= ST_TX_LSB;
        ST_ALU_A: if (RX_D_VLD) begin
          RF_ADDR    <= ADDR_WIDTH'(OPA_ADDR);
          RF_WR_DATA <= RX_P_DATA;
          RF_WR_EN   <= 1'b1;
          state      <= ST_ALU_B;
        end
        ST_ALU_B: if (RX_D_VLD) begin
          RF_ADDR    <= ADDR_WIDTH'(OPB_ADDR);
          RF_WR_DATA <= RX_P_DATA;
          RF_WR_EN   <= 1'b1;
          state      <= ST_ALU_FN;
        end
        // Clock gate opens one cycle ahead of the enable so the ALU sees a live clock.
        ST_ALU_FN: begin
          if (fn_got) begin
            fn_got <= 1'b0;
            ALU_EN <= 1'b1;
            state  <= ST_ALU_WAIT;
          end else if (RX_D_VLD) begin
            ALU_FUN    <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
            ALU_CLK_EN <= 1'b1;
            fn_got     <= 1'b1;
          end
        end
        ST_ALU_WAIT: if (ALU_OUT_VLD) begin
          ALU_CLK_EN <= 1'b0;
          state      <= ST_TX_LSB;
        end
        ST_TX_LSB: if (TX_FIFO_WR) state <= two_byte ? ST_TX_MSB : ST_IDLE;
        ST_TX_MSB: if (TX_FIFO_WR) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sys_ctrl_tx_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .RES_WIDTH  (ALU_OUT_WIDTH)
  ) u_tx_seq (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (res_load),
    .load_data (res_data),
    .load_two  (res_two),
    .send_lsb  (state == ST_TX_LSB),
    .send_msb  (state == ST_TX_MSB),
    .fifo_full (TX_FIFO_FULL),
    .fifo_data (TX_FIFO_DATA),
    .fifo_wr   (TX_FIFO_WR),
    .two_byte  (two_byte)
  );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: register-file / ALU / FIFO stand-ins plus a frame-level
// scoreboard predicting RF writes, ALU launches and response bytes.
module tb_sys_cmd_ctrl;
  import sys_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN, RF_RD_EN;
  logic [7:0]  RF_WR_DATA;
  logic [7:0]  RF_RD_DATA = 8'h00;
  logic        RF_RD_VLD = 1'b0;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, ALU_CLK_EN;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        ALU_OUT_VLD = 1'b0;
  logic [7:0]  TX_FIFO_DATA;
  logic        TX_FIFO_WR;
  logic        TX_FIFO_FULL = 1'b0;
  logic        BUSY;

  always #5 CLK = ~CLK;

  sys_cmd_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .ALU_CLK_EN(ALU_CLK_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_FIFO_DATA(TX_FIFO_DATA), .TX_FIFO_WR(TX_FIFO_WR),
    .TX_FIFO_FULL(TX_FIFO_FULL), .BUSY(BUSY)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {a, b};
      4'd8:    return 16'h0011;
      default: return 16'(a ^ b);
    endcase
  endfunction

  // Register file and ALU stand-ins
  logic [7:0] rf [16] = '{default: 8'h00};
  int         alu_cnt = 0;
  logic [15:0] alu_pend = 16'h0000;

  always @(posedge CLK) begin
    RF_RD_VLD <= 1'b0;
    if (RF_WR_EN) rf[RF_ADDR] <= RF_WR_DATA;
    if (RF_RD_EN) begin
      RF_RD_VLD  <= 1'b1;
      RF_RD_DATA <= rf[RF_ADDR];
    end
  end

  always @(posedge CLK) begin
    ALU_OUT_VLD <= 1'b0;
    if (!RST_N) alu_cnt <= 0;
    else if (ALU_EN) begin
      alu_cnt  <= 6;
      alu_pend <= alu_ref(ALU_FUN, rf[0], rf[1]);
    end else if (alu_cnt == 1) begin
      ALU_OUT_VLD <= 1'b1;
      ALU_OUT     <= alu_pend;
      alu_cnt     <= 0;
    end else if (alu_cnt > 1) alu_cnt <= alu_cnt - 1;
  end

  // FIFO back-pressure driver
  bit force_full = 0;
  bit rand_full = 0;
  bit sim_done = 0;
  initial begin
    while (!sim_done) begin
      @(posedge CLK); #1;
      TX_FIFO_FULL = force_full | (rand_full & ($urandom_range(0, 2) == 0));
    end
  end

  // Observation
  logic [15:0] obs_wr[$];
  logic [7:0]  obs_tx[$];
  logic [3:0]  obs_fun[$];
  int cyc = 0, wr_while_full = 0, en_bad = 0, last_rdvld_cyc = 0, last_tx_lat = 0;

  always @(negedge CLK) begin
    cyc++;
    if (RF_WR_EN) obs_wr.push_back({4'h0, RF_ADDR, RF_WR_DATA});
    if (TX_FIFO_WR) begin
      obs_tx.push_back(TX_FIFO_DATA);
      if (TX_FIFO_FULL) wr_while_full++;
      last_tx_lat = cyc - last_rdvld_cyc;
    end
    if (ALU_EN) begin
      obs_fun.push_back(ALU_FUN);
      if (!ALU_CLK_EN) en_bad++;
    end
    if (RF_RD_VLD) last_rdvld_cyc = cyc;
  end

  // Frame-level model
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [3:0]  exp_fun[$];
  logic [7:0]  model_regs [16] = '{default: 8'h00};

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic gap();
    idle($urandom_range(0, 2));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (BUSY && k < 500) begin idle(1); k++; end
    check({tag, "_done"}, 32'(k < 500), 1);
    idle(2);
  endtask

  task automatic compare_sb(input string tag);
    check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) check({tag, "_wr"}, obs_wr[i], exp_wr[i]);
    check({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
    for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++) check({tag, "_tx"}, obs_tx[i], exp_tx[i]);
    check({tag, "_nfun"}, obs_fun.size(), exp_fun.size());
    for (int i = 0; i < obs_fun.size() && i < exp_fun.size(); i++) check({tag, "_fun"}, obs_fun[i], exp_fun[i]);
    check({tag, "_clken"}, ALU_CLK_EN, 0);
    obs_wr.delete(); obs_tx.delete(); obs_fun.delete();
    exp_wr.delete(); exp_tx.delete(); exp_fun.delete();
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d);
    send_byte(CMD_RF_WR); gap(); send_byte(a); gap(); send_byte(d);
    exp_wr.push_back({4'h0, a[3:0], d});
    model_regs[a[3:0]] = d;
  endtask

  task automatic rd_frame(input logic [7:0] a);
    send_byte(CMD_RF_RD); gap(); send_byte(a);
    exp_tx.push_back(model_regs[a[3:0]]);
  endtask

  task automatic alu_frame(input bit ops, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] f, input bit stray);
    logic [15:0] r;
    if (ops) begin
      send_byte(CMD_ALU_OP); gap(); send_byte(x); gap(); send_byte(y); gap();
      exp_wr.push_back({4'h0, 4'h0, x});
      exp_wr.push_back({4'h0, 4'h1, y});
      model_regs[0] = x;
      model_regs[1] = y;
    end else begin
      send_byte(CMD_ALU_NOP); gap();
    end
    send_byte(f);
    exp_fun.push_back(f[3:0]);
    r = alu_ref(f[3:0], model_regs[0], model_regs[1]);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
    if (stray) begin idle(2); send_byte(CMD_RF_WR); end
  endtask

  initial begin
    logic [7:0] b;
    int k;
    RST_N = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = 8'h00;
    idle(3);
    check("rst_busy", BUSY, 0);
    check("rst_wr_en", RF_WR_EN, 0);
    check("rst_rd_en", RF_RD_EN, 0);
    check("rst_alu_en", ALU_EN, 0);
    check("rst_clk_en", ALU_CLK_EN, 0);
    check("rst_tx_wr", TX_FIFO_WR, 0);
    check("rst_tx_data", TX_FIFO_DATA, 0);
    check("rst_addr", RF_ADDR, 0);
    check("rst_fun", ALU_FUN, 0);
    RST_N = 1'b1;
    idle(2);

    // Register write with commit latency, then read back
    send_byte(CMD_RF_WR); send_byte(8'h05); send_byte(8'hAB);
    check("wr_lat_en", RF_WR_EN, 1);
    check("wr_lat_addr", RF_ADDR, 5);
    check("wr_lat_data", RF_WR_DATA, 8'hAB);
    exp_wr.push_back(16'h05AB); model_regs[5] = 8'hAB;
    wait_idle("wr"); compare_sb("wr");
    rd_frame(8'h05);
    wait_idle("rd");
    check("rd_lat", last_tx_lat, 1);
    check("rd_byte", (obs_tx.size() > 0) ? obs_tx[0] : 8'hxx, 8'hAB);
    compare_sb("rd");

    alu_frame(1, 8'd200, 8'd200, 8'h02, 0);
    wait_idle("alu_op");
    check("alu_fun2", ALU_FUN, 2);
    check("alu_9c40", {(obs_tx.size() > 1) ? obs_tx[1] : 8'hxx, (obs_tx.size() > 0) ? obs_tx[0] : 8'hxx}, 16'h9C40);
    compare_sb("alu_op");

    alu_frame(0, 8'h00, 8'h00, 8'h08, 0);
    wait_idle("alu_nop");
    check("alu_fun8", ALU_FUN, 8);
    compare_sb("alu_nop");

    send_byte(8'h55);
    check("stray_idle_busy", BUSY, 0);
    idle(2);
    alu_frame(1, 8'h12, 8'h34, 8'h00, 1);
    wait_idle("stray_wait"); compare_sb("stray_wait");

    // Back-pressure across a two-byte response
    force_full = 1; idle(2);
    alu_frame(1, 8'h37, 8'h59, 8'h03, 0);
    k = 0;
    while ((ALU_CLK_EN || !BUSY) && k < 200) begin idle(1); k++; end
    check("bp_reach_tx", 32'(k < 200), 1);
    idle(10); send_byte(CMD_RF_RD); idle(9);
    check("bp_held_ntx", obs_tx.size(), 0);
    check("bp_held_busy", BUSY, 1);
    force_full = 0;
    wait_idle("bp"); compare_sb("bp");

    // Reset in the middle of a write and of an ALU launch
    send_byte(CMD_RF_WR); send_byte(8'h03);
    RST_N = 1'b0; idle(2);
    check("rmid_busy", BUSY, 0);
    check("rmid_wr_en", RF_WR_EN, 0);
    RST_N = 1'b1; idle(1);
    wr_frame(8'h04, 8'h11);
    wait_idle("rmid_wr"); compare_sb("rmid_wr");
    send_byte(CMD_ALU_NOP); send_byte(8'h05);
    check("rmid_clk_on", ALU_CLK_EN, 1);
    RST_N = 1'b0; idle(1);
    check("rmid_clk_off", ALU_CLK_EN, 0);
    check("rmid_alu_busy", BUSY, 0);
    RST_N = 1'b1; idle(8);
    compare_sb("rmid_alu");

    // Randomized frames with random back-pressure and stray idle bytes
    rand_full = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: wr_frame(8'($urandom), 8'($urandom));
        1: rd_frame(8'($urandom));
        2: alu_frame(1, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 1));
        3: alu_frame(0, 8'h00, 8'h00, 8'($urandom), $urandom_range(0, 1));
        default: begin
          b = 8'($urandom);
          if (b == CMD_RF_WR || b == CMD_RF_RD || b == CMD_ALU_OP || b == CMD_ALU_NOP) b = 8'h55;
          send_byte(b);
          check("rnd_stray_busy", BUSY, 0);
        end
      endcase
      wait_idle("rnd");
      compare_sb("rnd");
    end
    rand_full = 0;
    idle(3);
    sim_done = 1;
    check("wr_while_full", wr_while_full, 0);
    check("alu_en_ungated", en_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
